// File: rtl/fast_field_packer.sv
// Stop-bit encoder and byte packer for FAST transmit fields.
// Encoded bytes are staged, then emitted as beat-wide words, lane 0 first.
module fast_field_packer #(
    parameter int BEAT_WIDTH  = 64,
    parameter int FIELD_WIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [FIELD_WIDTH-1:0]  in_value,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [BEAT_WIDTH-1:0]   out_data,
    output logic [BEAT_WIDTH/8-1:0] out_keep,
    output logic                    out_last
);

    localparam int BB   = BEAT_WIDTH / 8;
    localparam int MAXB = (FIELD_WIDTH + 6) / 7;
    localparam int SB   = 2 * BB;
    localparam int CW   = $clog2(SB);
    localparam int PW   = MAXB * 7;

    logic [7:0]    stage     [SB];
    logic [7:0]    stage_nxt [SB];
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          last_pend;
    logic          last_nxt;

    logic [PW-1:0] vpad;
    logic [6:0]    grp [MAXB];
    logic [CW-1:0] len;
    logic [7:0]    enc [MAXB];

    logic          in_fire;
    logic          out_fire;

    // Handshake qualifiers; accept and emit never overlap.
    assign in_ready = ~out_valid;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = out_valid & out_ready;

    // Beat is ready once a full beat is staged or the message tail is in.
    assign out_valid = (cnt >= CW'(BB)) | (last_pend & (cnt != '0));
    assign out_last  = last_pend & (cnt <= CW'(BB));

    // Split the value into 7-bit groups, least significant first.
    always_comb begin
        vpad = PW'(in_value);
        for (int i = 0; i < MAXB; i++) begin
            grp[i] = vpad[7*i +: 7];
        end
    end

    // Encoded length: up to the most significant nonzero group, at least 1.
    always_comb begin
        len = CW'(1);
        for (int i = 0; i < MAXB; i++) begin
            if (grp[i] != 7'd0) begin
                len = CW'(i + 1);
            end
        end
    end

    // Byte j carries group len-1-j; only the final byte gets the stop bit.
    always_comb begin
        for (int j = 0; j < MAXB; j++) begin
            enc[j] = 8'h00;
            for (int i = 0; i < MAXB; i++) begin
                if (CW'(i + j + 1) == len) begin
                    enc[j] = {(CW'(j + 1) == len), grp[i]};
                end
            end
        end
    end

    // Next staging state: drain a beat, or append an accepted field.
    always_comb begin
        stage_nxt = stage;
        cnt_nxt   = cnt;
        last_nxt  = last_pend;
        if (out_fire) begin
            if (cnt > CW'(BB)) begin
                for (int l = 0; l < BB; l++) begin
                    stage_nxt[l] = stage[l + BB];
                end
                for (int l = BB; l < SB; l++) begin
                    stage_nxt[l] = 8'h00;
                end
                cnt_nxt = cnt - CW'(BB);
            end else begin
                for (int l = 0; l < SB; l++) begin
                    stage_nxt[l] = 8'h00;
                end
                cnt_nxt  = '0;
                last_nxt = 1'b0;
            end
        end else if (in_fire) begin
            for (int l = 0; l < SB; l++) begin
                for (int j = 0; j < MAXB; j++) begin
                    if ((CW'(j) < len) && (CW'(l) == cnt + CW'(j))) begin
                        stage_nxt[l] = enc[j];
                    end
                end
            end
            cnt_nxt = cnt + len;
            if (in_last) begin
                last_nxt = 1'b1;
            end
        end
    end

    // Present the low beat; lanes beyond the fill count read as zero.
    always_comb begin
        out_data = '0;
        out_keep = '0;
        for (int l = 0; l < BB; l++) begin
            if (CW'(l) < cnt) begin
                out_data[8*l +: 8] = stage[l];
                out_keep[l]        = 1'b1;
            end
        end
    end

    // Staging registers; reset drops any partial message at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int l = 0; l < SB; l++) begin
                stage[l] <= 8'h00;
            end
            cnt       <= '0;
            last_pend <= 1'b0;
        end else begin
            stage     <= stage_nxt;
            cnt       <= cnt_nxt;
            last_pend <= last_nxt;
        end
    end

endmodule

// File: tb/tb_fast_field_packer.sv
// Directed bench for fast_field_packer.
// Expected beats queue up at stimulus time; a monitor checks each beat.
module tb_fast_field_packer;

    typedef struct packed {
        logic [63:0] d;
        logic [7:0]  k;
        logic        l;
    } beat_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_value;
    logic        in_last;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic [7:0]  out_keep;
    logic        out_last;

    beat_t exp_q[$];
    int vectors;
    int miscompares;

    fast_field_packer #(
        .BEAT_WIDTH (64),
        .FIELD_WIDTH(32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_value (in_value),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_keep (out_keep),
        .out_last (out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act,
                                logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Monitor: sample at negedge, a beat moves on the following posedge.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_beat", out_data, 64'hx);
            end else begin
                beat_t e;
                e = exp_q.pop_front();
                chk("beat_data", out_data, e.d);
                chk("beat_keep", {56'd0, out_keep}, {56'd0, e.k});
                chk("beat_last", {63'd0, out_last}, {63'd0, e.l});
            end
        end
    end

    task automatic push(input logic [63:0] d, input logic [7:0] k,
                        input logic l);
        beat_t b;
        b.d = d;
        b.k = k;
        b.l = l;
        exp_q.push_back(b);
    endtask

    task automatic send(input logic [31:0] v, input logic last);
        int n;
        in_valid = 1'b1;
        in_value = v;
        in_last  = last;
        n = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 64'd0, 64'd1);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_value = 32'd0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_value    = 32'd0;
        in_last     = 1'b0;
        out_ready   = 1'b1;

        // Reset state
        #12;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_out_data", out_data, 64'd0);
        chk("rst_out_keep", {56'd0, out_keep}, 64'd0);
        chk("rst_out_last", {63'd0, out_last}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // 300 -> 02 AC
        push(64'h000000000000AC02, 8'h03, 1'b1);
        send(32'd300, 1'b1);
        drain();

        // 0 -> 80
        push(64'h0000000000000080, 8'h01, 1'b1);
        send(32'd0, 1'b1);
        drain();

        // 1..8 exact fill, last on the boundary beat
        push(64'h8887868584838281, 8'hFF, 1'b1);
        for (int i = 1; i <= 7; i++) begin
            send(32'(i), 1'b0);
        end
        chk("pre_fill_valid", {63'd0, out_valid}, 64'd0);
        send(32'd8, 1'b1);
        chk("fill_latency_valid", {63'd0, out_valid}, 64'd1);
        drain();

        // Two 5-byte fields straddling a beat
        push(64'h7F7F0FFF7F7F7F0F, 8'hFF, 1'b0);
        push(64'h000000000000FF7F, 8'h03, 1'b1);
        send(32'hFFFFFFFF, 1'b0);
        send(32'hFFFFFFFF, 1'b1);
        drain();

        // Backpressure with a field offered during the stall
        out_ready = 1'b0;
        push(64'h000000000000AC02, 8'h03, 1'b1);
        push(64'h0000000000000085, 8'h01, 1'b1);
        send(32'd300, 1'b1);
        in_valid = 1'b1;
        in_value = 32'd5;
        in_last  = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_data", out_data, 64'h000000000000AC02);
            chk("bp_keep", {56'd0, out_keep}, 64'h03);
            chk("bp_last", {63'd0, out_last}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_released", {63'd0, out_valid}, 64'd0);
        send(32'd5, 1'b1);
        drain();

        // Asynchronous reset mid-message discards staged bytes
        send(32'd300, 1'b0);
        send(32'd5, 1'b0);
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
        chk("mid_rst_keep", {56'd0, out_keep}, 64'd0);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        push(64'h0000000000000087, 8'h01, 1'b1);
        send(32'd7, 1'b1);
        drain();

        // Nothing further may appear
        repeat (4) @(negedge clk);
        chk("idle_valid", {63'd0, out_valid}, 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
